// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, field positions and default program image for cpu_core
package cpu_pkg;

    localparam int DATA_W  = 8;
    localparam int INSTR_W = 16;
    localparam int PC_W    = 8;
    localparam int NREGS   = 4;
    localparam int ROM_DEPTH = 256;

    // Instruction field positions
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 10;
    localparam int RS_MSB  = 9;
    localparam int RS_LSB  = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_MOV  = 4'h7;
    localparam logic [3:0] OP_ADDI = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_BEQZ = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hB;

    // Default program: count R3 upward forever once the BEQZ skips the 0xEE load
    localparam logic [INSTR_W-1:0] ROM_IMAGE [ROM_DEPTH] = '{
        0: 16'h1005,
        1: 16'h1403,
        2: 16'h2100,
        3: 16'h3100,
        4: 16'h6A00,
        5: 16'hA807,
        6: 16'h1CEE,
        7: 16'h8C01,
        8: 16'h9007,
        default: 16'h0000
    };

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational ALU producing the writeback value for each opcode
module alu
    import cpu_pkg::*;
(
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] y
);

    // Result is the value to be written back; non-writing opcodes yield zero
    always_comb begin
        y = '0;
        case (op)
            OP_LDI:  y = imm;
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_MOV:  y = b;
            OP_ADDI: y = a + imm;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/cpu_core.sv
// rtl/cpu_core.sv - single-cycle 8-bit register CPU with internal program ROM
module cpu_core
    import cpu_pkg::*;
(
    input logic clk,
    input logic reset
);

    logic [PC_W-1:0]    pc_out;
    logic [INSTR_W-1:0] instr;
    logic [DATA_W-1:0]  reg_a;
    logic [DATA_W-1:0]  reg_b;
    logic [DATA_W-1:0]  alu_result;

    logic [INSTR_W-1:0] rom [ROM_DEPTH];
    logic [DATA_W-1:0]  regs [NREGS];

    logic [3:0]         opcode;
    logic [1:0]         rd;
    logic [1:0]         rs;
    logic [DATA_W-1:0]  imm;
    logic               reg_we;
    logic [PC_W-1:0]    next_pc;

    assign rom   = ROM_IMAGE;
    assign instr = rom[pc_out];

    assign opcode = instr[OP_MSB:OP_LSB];
    assign rd     = instr[RD_MSB:RD_LSB];
    assign rs     = instr[RS_MSB:RS_LSB];
    assign imm    = instr[IMM_MSB:IMM_LSB];

    assign reg_a = regs[rd];
    assign reg_b = regs[rs];

    alu u_alu (
        .op  (opcode),
        .a   (reg_a),
        .b   (reg_b),
        .imm (imm),
        .y   (alu_result)
    );

    // Decode writeback enable and next PC; pc+1 wraps naturally at 8 bits
    always_comb begin
        reg_we  = 1'b0;
        next_pc = pc_out + 8'd1;
        case (opcode)
            OP_LDI, OP_ADD, OP_SUB, OP_AND,
            OP_OR, OP_XOR, OP_MOV, OP_ADDI: reg_we = 1'b1;
            OP_JMP:  next_pc = imm;
            OP_BEQZ: if (reg_a == '0) next_pc = imm;
            OP_HALT: next_pc = pc_out;
            default: ;
        endcase
    end

    // Program counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_out <= '0;
        end else begin
            pc_out <= next_pc;
        end
    end

    // Register file write port; reset discards the in-flight write
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (reg_we) begin
            regs[rd] <= alu_result;
        end
    end

endmodule

// File: tb/tb_cpu_core.sv
// tb/tb_cpu_core.sv - directed self-checking bench for cpu_core
module tb_cpu_core;

    logic clk;
    logic reset;

    int vectors;
    int miscompares;

    cpu_core dut (
        .clk   (clk),
        .reset (reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (dut.pc_out !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_pc: got %h want 00", dut.pc_out);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (dut.regs[i] !== 8'h00) begin
                miscompares++;
                $display("FAIL reset_r%0d: got %h want 00", i, dut.regs[i]);
            end
        end
    endtask

    task automatic test_program();
        logic [7:0] r3_exp;
        reset = 1'b0;
        // PC 0: LDI R0,5
        vectors++;
        if (dut.instr !== 16'h1005 || dut.alu_result !== 8'h05) begin
            miscompares++;
            $display("FAIL pc0_fetch: instr %h alu %h want 1005 05", dut.instr, dut.alu_result);
        end
        @(negedge clk);
        vectors++;
        if (dut.pc_out !== 8'h01 || dut.regs[0] !== 8'h05 || dut.alu_result !== 8'h03) begin
            miscompares++;
            $display("FAIL pc1: pc %h r0 %h alu %h want 01 05 03", dut.pc_out, dut.regs[0], dut.alu_result);
        end
        @(negedge clk);
        vectors++;
        if (dut.pc_out !== 8'h02 || dut.regs[1] !== 8'h03 || dut.alu_result !== 8'h08
            || dut.reg_a !== 8'h05 || dut.reg_b !== 8'h03) begin
            miscompares++;
            $display("FAIL pc2_add: pc %h r1 %h alu %h a %h b %h want 02 03 08 05 03",
                     dut.pc_out, dut.regs[1], dut.alu_result, dut.reg_a, dut.reg_b);
        end
        @(negedge clk);
        vectors++;
        if (dut.pc_out !== 8'h03 || dut.regs[0] !== 8'h08 || dut.alu_result !== 8'h05) begin
            miscompares++;
            $display("FAIL pc3_sub: pc %h r0 %h alu %h want 03 08 05", dut.pc_out, dut.regs[0], dut.alu_result);
        end
        @(negedge clk);
        vectors++;
        if (dut.pc_out !== 8'h04 || dut.regs[0] !== 8'h05 || dut.alu_result !== 8'h00) begin
            miscompares++;
            $display("FAIL pc4_xor: pc %h r0 %h alu %h want 04 05 00", dut.pc_out, dut.regs[0], dut.alu_result);
        end
        @(negedge clk);
        vectors++;
        if (dut.pc_out !== 8'h05 || dut.regs[2] !== 8'h00 || dut.alu_result !== 8'h00) begin
            miscompares++;
            $display("FAIL pc5_beqz: pc %h r2 %h alu %h want 05 00 00", dut.pc_out, dut.regs[2], dut.alu_result);
        end
        @(negedge clk);
        vectors++;
        if (dut.pc_out !== 8'h07 || dut.regs[3] !== 8'h00 || dut.alu_result !== 8'h01) begin
            miscompares++;
            $display("FAIL beqz_taken: pc %h r3 %h alu %h want 07 00 01", dut.pc_out, dut.regs[3], dut.alu_result);
        end
        // Loop 7<->8, R3 counts up and wraps after 256 passes
        r3_exp = 8'h00;
        for (int pass = 1; pass <= 260; pass++) begin
            r3_exp = r3_exp + 8'd1;
            @(negedge clk);
            vectors++;
            if (dut.pc_out !== 8'h08 || dut.regs[3] !== r3_exp) begin
                miscompares++;
                $display("FAIL loop_addi pass %0d: pc %h r3 %h want 08 %h", pass, dut.pc_out, dut.regs[3], r3_exp);
            end
            @(negedge clk);
            vectors++;
            if (dut.pc_out !== 8'h07) begin
                miscompares++;
                $display("FAIL loop_jmp pass %0d: pc %h want 07", pass, dut.pc_out);
            end
        end
        vectors++;
        if (dut.regs[3] !== 8'h04) begin
            miscompares++;
            $display("FAIL loop_wrap: r3 %h want 04", dut.regs[3]);
        end
    endtask

    task automatic test_reset_midloop();
        logic [7:0] exp_pc [10] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h07, 8'h08, 8'h07, 8'h08};
        logic [7:0] exp_r0 [10] = '{8'h00, 8'h05, 8'h05, 8'h08, 8'h05, 8'h05, 8'h05, 8'h05, 8'h05, 8'h05};
        logic [7:0] exp_r1 [10] = '{8'h00, 8'h00, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03};
        logic [7:0] exp_r3 [10] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h02};
        // Currently at PC 7 with ADDI pending; reset must discard it
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (dut.pc_out !== exp_pc[i] || dut.regs[0] !== exp_r0[i] || dut.regs[1] !== exp_r1[i]
                || dut.regs[2] !== 8'h00 || dut.regs[3] !== exp_r3[i]) begin
                miscompares++;
                $display("FAIL replay step %0d: pc %h r0 %h r1 %h r2 %h r3 %h want %h %h %h 00 %h",
                         i, dut.pc_out, dut.regs[0], dut.regs[1], dut.regs[2], dut.regs[3],
                         exp_pc[i], exp_r0[i], exp_r1[i], exp_r3[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_alu_ops();
        logic [15:0] ins    [15] = '{16'h10F0, 16'h143C, 16'h4100, 16'h5400, 16'h7900,
                                     16'h2900, 16'h3E00, 16'h8C80, 16'hAC40, 16'hCFFF,
                                     16'h90FE, 16'h0000, 16'h0000, 16'hBFFF, 16'hFAAA};
        logic [7:0]  e_alu  [15] = '{8'hF0, 8'h3C, 8'h30, 8'h3C, 8'h3C,
                                     8'h78, 8'h88, 8'h08, 8'h00, 8'h00,
                                     8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        logic [7:0]  e_pc   [15] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                                     8'h06, 8'h07, 8'h08, 8'h09, 8'h0A,
                                     8'hFE, 8'hFF, 8'h00, 8'h00, 8'h01};
        int          e_rd   [15] = '{0, 1, 0, 1, 2, 2, 3, 3, 3, 3, 0, 0, 0, 3, 2};
        logic [7:0]  e_val  [15] = '{8'hF0, 8'h3C, 8'h30, 8'h3C, 8'h3C,
                                     8'h78, 8'h88, 8'h08, 8'h08, 8'h08,
                                     8'h30, 8'h30, 8'h30, 8'h08, 8'h78};
        logic [15:0] cur;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            cur = ins[i];
            force dut.instr = cur;
            #1;
            vectors++;
            if (dut.alu_result !== e_alu[i]) begin
                miscompares++;
                $display("FAIL op_alu %h: got %h want %h", cur, dut.alu_result, e_alu[i]);
            end
            @(negedge clk);
            vectors++;
            if (dut.pc_out !== e_pc[i] || dut.regs[e_rd[i]] !== e_val[i]) begin
                miscompares++;
                $display("FAIL op_commit %h: pc %h r%0d %h want %h %h",
                         cur, dut.pc_out, e_rd[i], dut.regs[e_rd[i]], e_pc[i], e_val[i]);
            end
        end
        release dut.instr;
    endtask

    task automatic test_halt();
        logic [15:0] halt_word;
        halt_word = 16'hB000;
        reset = 1'b1;
        @(negedge clk);
        force dut.instr = halt_word;
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            vectors++;
            if (dut.pc_out !== 8'h00 || dut.alu_result !== 8'h00 || dut.regs[0] !== 8'h00
                || dut.regs[1] !== 8'h00 || dut.regs[2] !== 8'h00 || dut.regs[3] !== 8'h00) begin
                miscompares++;
                $display("FAIL halt cycle %0d: pc %h alu %h r0 %h r1 %h r2 %h r3 %h want all 00",
                         c, dut.pc_out, dut.alu_result, dut.regs[0], dut.regs[1], dut.regs[2], dut.regs[3]);
            end
        end
        release dut.instr;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        test_reset();
        test_program();
        test_reset_midloop();
        test_alu_ops();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
